// File: rtl/regs_wport_arb.sv
// Write-port arbiter for the 32x32 GPR file (x0 hard-wired zero).
// Three sources share one port. Execute writeback (ex) always wins. Delayed mem
// writeback is buffered in a small FIFO. A single debug write (dbg) outranks the
// FIFO once it has waited STARVE_MAX cycles.
// pend_o flags registers that still have a live write queued in the FIFO.
// Optional feature: define REGS_ARB_BYPASS_EN so that a mem write arriving on an
// idle port with an empty FIFO goes straight to the port (latency 0).
`timescale 1ns/1ps

module regs_wport_arb #(
  parameter int unsigned FIFO_DEPTH = 2,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ex_we_i,
  input  logic [4:0]  ex_waddr_i,
  input  logic [31:0] ex_wdata_i,
  input  logic        mem_valid_i,
  output logic        mem_ready_o,
  input  logic [4:0]  mem_waddr_i,
  input  logic [31:0] mem_wdata_i,
  input  logic        dbg_valid_i,
  output logic        dbg_ready_o,
  input  logic [4:0]  dbg_waddr_i,
  input  logic [31:0] dbg_wdata_i,
  output logic        we_o,
  output logic [4:0]  waddr_o,
  output logic [31:0] wdata_o,
  output logic [31:0] pend_o
);

  localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
  localparam int unsigned CntW = $clog2(FIFO_DEPTH + 1);

  typedef enum logic [2:0] {GntNone, GntEx, GntDbg, GntMem, GntByp} gnt_e;

  logic [4:0]          fifo_addr_q [FIFO_DEPTH];
  logic [31:0]         fifo_data_q [FIFO_DEPTH];
  // Live = occupied and not cancelled by a younger ex write.
  logic [FIFO_DEPTH-1:0] live_q, live_d;
  logic [PtrW-1:0]     rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CntW-1:0]     count_q, count_d;
  logic [3:0]          wait_q, wait_d;

  logic            ex_grant, dbg_req, wait_at_max, fifo_full, enq;
  logic            head_found;
  logic [PtrW-1:0] head_idx, slot, pslot;
  logic [CntW-1:0] skip, pops;
  gnt_e            gnt;

  assign ex_grant    = ex_we_i && (ex_waddr_i != 5'd0);
  assign dbg_req     = dbg_valid_i && (dbg_waddr_i != 5'd0);
  assign wait_at_max = (wait_q == 4'(STARVE_MAX));
  assign fifo_full   = (count_q == CntW'(FIFO_DEPTH));
  assign mem_ready_o = !fifo_full;

  // Find the first live entry from the head; cancelled entries ahead of it are skipped for free.
  always_comb begin
    skip       = '0;
    head_found = 1'b0;
    head_idx   = rd_ptr_q;
    slot       = '0;
    for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
      slot = rd_ptr_q + PtrW'(i);
      if (!head_found && (i < int'(count_q))) begin
        if (live_q[slot]) begin
          head_found = 1'b1;
          head_idx   = slot;
        end else begin
          skip = skip + CntW'(1);
        end
      end
    end
  end

  // Priority grant: ex, starved dbg, (bypass), dbg on empty FIFO, FIFO head, dbg.
  always_comb begin
    gnt = GntNone;
    if (ex_grant) begin
      gnt = GntEx;
    end else if (dbg_req && wait_at_max) begin
      gnt = GntDbg;
`ifdef REGS_ARB_BYPASS_EN
    end else if ((count_q == '0) && mem_valid_i && (mem_waddr_i != 5'd0)) begin
      gnt = GntByp;
`endif
    end else if (dbg_req && !head_found) begin
      gnt = GntDbg;
    end else if (head_found) begin
      gnt = GntMem;
    end else if (dbg_req) begin
      gnt = GntDbg;
    end
  end

  // Port mux driven by the grant.
  always_comb begin
    we_o    = 1'b0;
    waddr_o = '0;
    wdata_o = '0;
    unique case (gnt)
      GntEx: begin
        we_o    = 1'b1;
        waddr_o = ex_waddr_i;
        wdata_o = ex_wdata_i;
      end
      GntDbg: begin
        we_o    = 1'b1;
        waddr_o = dbg_waddr_i;
        wdata_o = dbg_wdata_i;
      end
      GntMem: begin
        we_o    = 1'b1;
        waddr_o = fifo_addr_q[head_idx];
        wdata_o = fifo_data_q[head_idx];
      end
      GntByp: begin
        we_o    = 1'b1;
        waddr_o = mem_waddr_i;
        wdata_o = mem_wdata_i;
      end
      default: begin
        we_o = 1'b0;
      end
    endcase
  end

  // Debug handshake and starvation counter; x0 writes are acknowledged without using the port.
  always_comb begin
    dbg_ready_o = dbg_valid_i && ((dbg_waddr_i == 5'd0) || (gnt == GntDbg));
    wait_d      = wait_q;
    if (!dbg_valid_i || dbg_ready_o) begin
      wait_d = '0;
    end else if (!wait_at_max) begin
      wait_d = wait_q + 4'd1;
    end
  end

  // FIFO bookkeeping: skips plus an optional granted pop, cancellation, and enqueue.
  always_comb begin
    enq      = mem_valid_i && !fifo_full && (mem_waddr_i != 5'd0) && (gnt != GntByp);
    pops     = skip + CntW'(gnt == GntMem);
    rd_ptr_d = rd_ptr_q + PtrW'(pops);
    wr_ptr_d = wr_ptr_q + PtrW'(enq);
    count_d  = count_q - pops + CntW'(enq);
    live_d   = live_q;
    pslot    = '0;
    for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
      if (ex_grant && (fifo_addr_q[i] == ex_waddr_i)) begin
        live_d[i] = 1'b0;
      end
    end
    for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
      pslot = rd_ptr_q + PtrW'(i);
      if (i < int'(pops)) begin
        live_d[pslot] = 1'b0;
      end
    end
    // Slot under wr_ptr is free whenever enq is allowed, so a same-cycle ex match cannot hit it.
    if (enq) begin
      live_d[wr_ptr_q] = 1'b1;
    end
  end

  // Pending-write scoreboard from live entries.
  always_comb begin
    pend_o = '0;
    for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
      if (live_q[i]) begin
        pend_o[fifo_addr_q[i]] = 1'b1;
      end
    end
    pend_o[0] = 1'b0;
  end

  // State registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
        fifo_addr_q[i] <= '0;
        fifo_data_q[i] <= '0;
      end
      live_q   <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      wait_q   <= '0;
    end else begin
      if (enq) begin
        fifo_addr_q[wr_ptr_q] <= mem_waddr_i;
        fifo_data_q[wr_ptr_q] <= mem_wdata_i;
      end
      live_q   <= live_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      wait_q   <= wait_d;
    end
  end

endmodule

// File: tb/tb_regs_wport_arb.sv
// Bench for regs_wport_arb: per-cycle vector table plus hand sequences for
// starvation and mid-operation reset. Expected GPR writes go into a queue that a
// monitor drains whenever the port writes.
`timescale 1ns/1ps

module tb_regs_wport_arb;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ex_we_i, mem_valid_i, dbg_valid_i;
  logic [4:0]  ex_waddr_i, mem_waddr_i, dbg_waddr_i;
  logic [31:0] ex_wdata_i, mem_wdata_i, dbg_wdata_i;
  logic        mem_ready_o, dbg_ready_o, we_o;
  logic [4:0]  waddr_o;
  logic [31:0] wdata_o, pend_o;

  always #5 clk = ~clk;

  regs_wport_arb #(.FIFO_DEPTH(2), .STARVE_MAX(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ex_we_i    (ex_we_i),
    .ex_waddr_i (ex_waddr_i),
    .ex_wdata_i (ex_wdata_i),
    .mem_valid_i(mem_valid_i),
    .mem_ready_o(mem_ready_o),
    .mem_waddr_i(mem_waddr_i),
    .mem_wdata_i(mem_wdata_i),
    .dbg_valid_i(dbg_valid_i),
    .dbg_ready_o(dbg_ready_o),
    .dbg_waddr_i(dbg_waddr_i),
    .dbg_wdata_i(dbg_wdata_i),
    .we_o       (we_o),
    .waddr_o    (waddr_o),
    .wdata_o    (wdata_o),
    .pend_o     (pend_o)
  );

  typedef struct {
    logic        ex_we;  logic [4:0] ex_a;  logic [31:0] ex_d;
    logic        mem_v;  logic [4:0] mem_a; logic [31:0] mem_d;
    logic        dbg_v;  logic [4:0] dbg_a; logic [31:0] dbg_d;
    logic        e_we;   logic [4:0] e_a;   logic [31:0] e_d;
    logic        e_mr;   logic       e_dr;  logic [31:0] e_pend;
  } vec_t;

  typedef struct packed {
    logic [4:0]  a;
    logic [31:0] d;
  } wr_t;

  int   n_vec = 0;
  int   n_bad = 0;
  logic mon_en = 1'b0;
  wr_t  exp_q[$];
  vec_t tbl[20];

  function automatic vec_t mk(input logic exw, input logic [4:0] exa, input logic [31:0] exd,
                              input logic mv, input logic [4:0] ma, input logic [31:0] md,
                              input logic dv, input logic [4:0] da, input logic [31:0] dd,
                              input logic ew, input logic [4:0] ea, input logic [31:0] ed,
                              input logic emr, input logic edr, input logic [31:0] ep);
    vec_t v;
    v.ex_we = exw; v.ex_a = exa; v.ex_d = exd;
    v.mem_v = mv;  v.mem_a = ma; v.mem_d = md;
    v.dbg_v = dv;  v.dbg_a = da; v.dbg_d = dd;
    v.e_we = ew; v.e_a = ea; v.e_d = ed; v.e_mr = emr; v.e_dr = edr; v.e_pend = ep;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, want %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic drive(input logic exw, input logic [4:0] exa, input logic [31:0] exd,
                       input logic mv, input logic [4:0] ma, input logic [31:0] md,
                       input logic dv, input logic [4:0] da, input logic [31:0] dd);
    ex_we_i = exw;  ex_waddr_i = exa;  ex_wdata_i = exd;
    mem_valid_i = mv; mem_waddr_i = ma; mem_wdata_i = md;
    dbg_valid_i = dv; dbg_waddr_i = da; dbg_wdata_i = dd;
  endtask

  task automatic push(input logic [4:0] a, input logic [31:0] d);
    wr_t w;
    w.a = a;
    w.d = d;
    exp_q.push_back(w);
  endtask

  // Monitor: every port write must match the oldest expected write.
  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (mon_en && we_o) begin
        if (exp_q.size() == 0) begin
          n_vec++;
          n_bad++;
          $display("FAIL sb_write: unexpected write x%0d=%h, want no write", waddr_o, wdata_o);
        end else begin
          wr_t w;
          w = exp_q.pop_front();
          chk("sb_waddr", {27'd0, waddr_o}, {27'd0, w.a});
          chk("sb_wdata", wdata_o, w.d);
        end
      end
    end
  end

  initial begin
    // Each row is one clock cycle; expectations are for that cycle, before the edge.
    tbl[0]  = mk(0, 0, 0,       0, 0, 0,      0, 0, 0,     0, 0, 0,       1, 0, 32'h0);
    tbl[1]  = mk(1, 5, 32'h11,  1, 6, 32'h22, 0, 0, 0,     1, 5, 32'h11,  1, 0, 32'h0);
    tbl[2]  = mk(0, 0, 0,       0, 0, 0,      0, 0, 0,     1, 6, 32'h22,  1, 0, 32'h40);
    tbl[3]  = mk(0, 0, 0,       0, 0, 0,      0, 0, 0,     0, 0, 0,       1, 0, 32'h0);
    tbl[4]  = mk(1, 1, 32'h100, 1, 7, 32'h77, 0, 0, 0,     1, 1, 32'h100, 1, 0, 32'h0);
    tbl[5]  = mk(1, 2, 32'h200, 1, 8, 32'h88, 0, 0, 0,     1, 2, 32'h200, 1, 0, 32'h80);
    tbl[6]  = mk(1, 3, 32'h300, 1, 9, 32'h99, 0, 0, 0,     1, 3, 32'h300, 0, 0, 32'h180);
    tbl[7]  = mk(0, 0, 0,       0, 0, 0,      0, 0, 0,     1, 7, 32'h77,  0, 0, 32'h180);
    tbl[8]  = mk(0, 0, 0,       0, 0, 0,      0, 0, 0,     1, 8, 32'h88,  1, 0, 32'h100);
    tbl[9]  = mk(0, 0, 0,       0, 0, 0,      0, 0, 0,     0, 0, 0,       1, 0, 32'h0);
    tbl[10] = mk(1, 11, 32'hB,  1, 10, 32'h1, 0, 0, 0,     1, 11, 32'hB,  1, 0, 32'h0);
    tbl[11] = mk(1, 10, 32'h2,  0, 0, 0,      0, 0, 0,     1, 10, 32'h2,  1, 0, 32'h400);
    tbl[12] = mk(0, 0, 0,       0, 0, 0,      0, 0, 0,     0, 0, 0,       1, 0, 32'h0);
    tbl[13] = mk(0, 0, 0,       0, 0, 0,      0, 0, 0,     0, 0, 0,       1, 0, 32'h0);
    tbl[14] = mk(1, 0, 32'hDEAD, 1, 0, 32'h5, 1, 0, 32'h77, 0, 0, 0,      1, 1, 32'h0);
    tbl[15] = mk(0, 0, 0,       0, 0, 0,      0, 0, 0,     0, 0, 0,       1, 0, 32'h0);
    tbl[16] = mk(0, 0, 0,       0, 0, 0,      1, 4, 32'h44, 1, 4, 32'h44, 1, 1, 32'h0);
    tbl[17] = mk(1, 13, 32'h5,  0, 0, 0,      1, 12, 32'hC, 1, 13, 32'h5, 1, 0, 32'h0);
    tbl[18] = mk(0, 0, 0,       0, 0, 0,      1, 12, 32'hC, 1, 12, 32'hC, 1, 1, 32'h0);
    tbl[19] = mk(0, 0, 0,       0, 0, 0,      0, 0, 0,     0, 0, 0,       1, 0, 32'h0);

    rst_n = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    #12;
    chk("rst_we", {31'd0, we_o}, 32'd0);
    chk("rst_mem_ready", {31'd0, mem_ready_o}, 32'd1);
    chk("rst_dbg_ready", {31'd0, dbg_ready_o}, 32'd0);
    chk("rst_pend", pend_o, 32'd0);
    @(negedge clk);
    rst_n  = 1'b1;
    mon_en = 1'b1;

    for (int r = 0; r < 20; r++) begin
      @(negedge clk);
      drive(tbl[r].ex_we, tbl[r].ex_a, tbl[r].ex_d, tbl[r].mem_v, tbl[r].mem_a, tbl[r].mem_d,
            tbl[r].dbg_v, tbl[r].dbg_a, tbl[r].dbg_d);
      if (tbl[r].e_we) push(tbl[r].e_a, tbl[r].e_d);
      #1;
      chk($sformatf("row%0d_we", r), {31'd0, we_o}, {31'd0, tbl[r].e_we});
      chk($sformatf("row%0d_mem_ready", r), {31'd0, mem_ready_o}, {31'd0, tbl[r].e_mr});
      chk($sformatf("row%0d_dbg_ready", r), {31'd0, dbg_ready_o}, {31'd0, tbl[r].e_dr});
      chk($sformatf("row%0d_pend", r), pend_o, tbl[r].e_pend);
    end

    // Starvation: dbg x9 held while mem keeps the FIFO non-empty.
    @(negedge clk);
    drive(1, 1, 32'h1, 1, 20, 32'd20, 0, 0, 0);
    push(5'd1, 32'h1);
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      drive(0, 0, 0, (k < 4), 5'(21 + k), 32'(21 + k), (k <= 4), 9, 32'hAB);
      if (k == 4) push(5'd9, 32'hAB);
      else if (k < 4) push(5'(20 + k), 32'(20 + k));
      else push(5'd24, 32'd24);
      #1;
      chk($sformatf("starve%0d_dbg_ready", k), {31'd0, dbg_ready_o}, {31'd0, (k == 4)});
    end
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    #1;
    chk("starve_idle_we", {31'd0, we_o}, 32'd0);
    chk("starve_idle_pend", pend_o, 32'd0);

    // Reset mid-operation discards queued entries.
    @(negedge clk);
    drive(1, 1, 32'h2, 1, 15, 32'hF, 0, 0, 0);
    push(5'd1, 32'h2);
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    mon_en = 1'b0;
    #1;
    chk("pre_rst_pend", pend_o, 32'h8000);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_we", {31'd0, we_o}, 32'd0);
    chk("mid_rst_pend", pend_o, 32'd0);
    chk("mid_rst_mem_ready", {31'd0, mem_ready_o}, 32'd1);
    @(negedge clk);
    rst_n  = 1'b1;
    mon_en = 1'b1;
    @(negedge clk);
    #1;
    chk("post_rst_we", {31'd0, we_o}, 32'd0);

`ifdef REGS_ARB_BYPASS_EN
    // Bypass: mem on an idle port with empty FIFO writes in the same cycle.
    @(negedge clk);
    drive(0, 0, 0, 1, 3, 32'h33, 0, 0, 0);
    push(5'd3, 32'h33);
    #1;
    chk("byp_we", {31'd0, we_o}, 32'd1);
    chk("byp_mem_ready", {31'd0, mem_ready_o}, 32'd1);
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    #1;
    chk("byp_next_we", {31'd0, we_o}, 32'd0);
    chk("byp_next_pend", pend_o, 32'd0);
`endif

    @(negedge clk);
    #3;
    chk("sb_drained", exp_q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
